hazard_sequencer: RTL and testbench

//  Central pipeline sequencer for the 5-stage core. Drives EN/flush for the
//  IF_ID, ID_EX, EX_MEM and MEM_WB pipe registers and the PC enable from
//  I/D memory handshakes, load-use hazards, EX-resolved branches and halt.

---
 rtl/hazard_sequencer.sv | 156 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Central pipeline sequencer for the 5-stage core. Produces the PC enable
//   and the EN/flush pair for each pipe register (IF_ID, ID_EX, EX_MEM,
//   MEM_WB) from memory handshakes, load-use hazards, EX branch redirects
//   and halt. Owns the halt-drain FSM and a saturating stall-cycle counter.
//
// Ports
//   CLK, nRST                 clock, async active-low reset
//   ihit, dhit                I-fetch / D-access completes this cycle
//   mem_dREN, mem_dWEN        MEM-stage load / store in flight
//   mem_halt                  halt instruction sits in MEM
//   ex_dREN, ex_wsel          EX-stage load and its destination register
//   id_rs, id_rt              ID-stage source registers
//   ex_br_taken               EX redirects the PC
//   pc_EN                     PC update enable
//   *_EN / *_flush            per pipe register enable / clear
//   halt                      core halted (sticky until reset)
//   stall_cnt                 RUN cycles with pc_EN=0, saturating
module hazard_sequencer #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_br_taken,
  output logic             pc_EN,
  output logic             ifid_EN,
  output logic             ifid_flush,
  output logic             idex_EN,
  output logic             idex_flush,
  output logic             exmem_EN,
  output logic             exmem_flush,
  output logic             memwb_EN,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic dstall, loaduse;
  // Raw decode before the reset gate; the counter uses pc_raw.
  logic pc_raw, ifid_en_raw, ifid_fl_raw, idex_en_raw, idex_fl_raw;
  logic exmem_en_raw, exmem_fl_raw, memwb_en_raw, memwb_fl_raw;

  assign dstall  = (mem_dREN | mem_dWEN) & ~dhit;
  // r0 is hardwired zero, so a load targeting it never creates a hazard.
  assign loaduse = ex_dREN & (ex_wsel != '0) &
                   ((ex_wsel == id_rs) | (ex_wsel == id_rt));

  always_comb begin
    pc_raw       = 1'b0;
    ifid_en_raw  = 1'b0;
    ifid_fl_raw  = 1'b0;
    idex_en_raw  = 1'b0;
    idex_fl_raw  = 1'b0;
    exmem_en_raw = 1'b0;
    exmem_fl_raw = 1'b0;
    memwb_en_raw = 1'b0;
    memwb_fl_raw = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (dstall) begin
          // whole pipe frozen waiting on data memory
        end else if (ex_br_taken) begin
          // redirect wins over load-use and a missing fetch: both younger
          // instructions are wrong-path anyway
          pc_raw       = 1'b1;
          ifid_fl_raw  = 1'b1;
          idex_fl_raw  = 1'b1;
          exmem_en_raw = 1'b1;
          memwb_en_raw = 1'b1;
        end else if (loaduse) begin
          // hold IF/ID, inject a bubble into ID_EX
          idex_fl_raw  = 1'b1;
          exmem_en_raw = 1'b1;
          memwb_en_raw = 1'b1;
        end else if (!ihit) begin
          ifid_fl_raw  = 1'b1;
          idex_en_raw  = 1'b1;
          exmem_en_raw = 1'b1;
          memwb_en_raw = 1'b1;
        end else begin
          pc_raw       = 1'b1;
          ifid_en_raw  = 1'b1;
          idex_en_raw  = 1'b1;
          exmem_en_raw = 1'b1;
          memwb_en_raw = 1'b1;
        end
      end
      S_DRAIN: begin
        // let the halt retire into WB, squash everything behind it
        ifid_fl_raw  = 1'b1;
        idex_fl_raw  = 1'b1;
        exmem_fl_raw = 1'b1;
        memwb_en_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are forced low while reset is held.
  assign pc_EN       = nRST & pc_raw;
  assign ifid_EN     = nRST & ifid_en_raw;
  assign ifid_flush  = nRST & ifid_fl_raw;
  assign idex_EN     = nRST & idex_en_raw;
  assign idex_flush  = nRST & idex_fl_raw;
  assign exmem_EN    = nRST & exmem_en_raw;
  assign exmem_flush = nRST & exmem_fl_raw;
  assign memwb_EN    = nRST & memwb_en_raw;
  assign memwb_flush = nRST & memwb_fl_raw;
  assign halt        = (state_q == S_HALTED);
  assign stall_cnt   = cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:    if (mem_halt && !dstall) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_HALTED;
      default:  state_d = S_HALTED;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_RUN && !pc_raw && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit = 1'b0, dhit = 1'b0, mem_dREN = 1'b0, mem_dWEN = 1'b0;
  logic       mem_halt = 1'b0, ex_dREN = 1'b0, ex_br_taken = 1'b0;
  logic [4:0] ex_wsel = '0, id_rs = '0, id_rt = '0;

  logic pc_EN, ifid_EN, ifid_flush, idex_EN, idex_flush;
  logic exmem_EN, exmem_flush, memwb_EN, memwb_flush, halt;
  logic [31:0] stall_cnt;

  logic s_pc, s_ifen, s_iffl, s_iden, s_idfl, s_exen, s_exfl, s_wben, s_wbfl, s_halt;
  logic [3:0] s_cnt;

  int errors = 0;
  int checks = 0;

  // {pc, ifid_EN, ifid_flush, idex_EN, idex_flush, exmem_EN, exmem_flush, memwb_EN, memwb_flush}
  localparam logic [8:0] C_RUN   = 9'b110101010;
  localparam logic [8:0] C_ZERO  = 9'b000000000;
  localparam logic [8:0] C_BR    = 9'b101011010;
  localparam logic [8:0] C_LU    = 9'b000011010;
  localparam logic [8:0] C_NOI   = 9'b001101010;
  localparam logic [8:0] C_DRAIN = 9'b001010110;

  wire [8:0] ctl = {pc_EN, ifid_EN, ifid_flush, idex_EN, idex_flush,
                    exmem_EN, exmem_flush, memwb_EN, memwb_flush};

  always #5 CLK = ~CLK;

  hazard_sequencer #(.REG_W(5), .CNT_W(32)) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .mem_halt(mem_halt), .ex_dREN(ex_dREN),
    .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .ex_br_taken(ex_br_taken),
    .pc_EN(pc_EN), .ifid_EN(ifid_EN), .ifid_flush(ifid_flush),
    .idex_EN(idex_EN), .idex_flush(idex_flush), .exmem_EN(exmem_EN),
    .exmem_flush(exmem_flush), .memwb_EN(memwb_EN), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cnt(stall_cnt));

  hazard_sequencer #(.REG_W(5), .CNT_W(4)) u_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .mem_halt(mem_halt), .ex_dREN(ex_dREN),
    .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .ex_br_taken(ex_br_taken),
    .pc_EN(s_pc), .ifid_EN(s_ifen), .ifid_flush(s_iffl),
    .idex_EN(s_iden), .idex_flush(s_idfl), .exmem_EN(s_exen),
    .exmem_flush(s_exfl), .memwb_EN(s_wben), .memwb_flush(s_wbfl),
    .halt(s_halt), .stall_cnt(s_cnt));

  // Inputs change 1ns after posedge; outputs are checked 2ns after that.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b1; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    mem_halt = 1'b0; ex_dREN = 1'b0; ex_br_taken = 1'b0;
    ex_wsel = '0; id_rs = '0; id_rt = '0;
  endtask

  task automatic do_reset();
    tick();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    #2;
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_ZERO); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b exp=0", halt); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_run();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      #2;
      checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL run_ctl cyc=%0d got=%b exp=%b", i, ctl, C_RUN); end
      tick();
    end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL run_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_loaduse();
    do_reset();
    idle_inputs();
    ex_dREN = 1'b1; ex_wsel = 5'd8; id_rt = 5'd8; id_rs = 5'd3;
    #2;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_ctl got=%b exp=%b", ctl, C_LU); end
    tick();
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    // match via rs as well
    id_rt = 5'd2; id_rs = 5'd8;
    #2;
    checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, C_LU); end
    tick();
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL lu_rs_cnt got=%0d exp=2", stall_cnt); end
    // r0 never a hazard
    ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #2;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_r0_ctl got=%b exp=%b", ctl, C_RUN); end
    tick();
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL lu_r0_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_dstall();
    do_reset();
    idle_inputs();
    mem_dREN = 1'b1; dhit = 1'b0; ex_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL dstall_ctl cyc=%0d got=%b exp=%b", i, ctl, C_ZERO); end
      tick();
    end
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL dstall_cnt got=%0d exp=3", stall_cnt); end
    dhit = 1'b1;
    #2;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL dstall_rel_ctl got=%b exp=%b", ctl, C_BR); end
    tick();
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL dstall_rel_cnt got=%0d exp=3", stall_cnt); end
    // store miss stalls too
    idle_inputs();
    mem_dWEN = 1'b1; dhit = 1'b0;
    #2;
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL dwen_ctl got=%b exp=%b", ctl, C_ZERO); end
    tick();
  endtask

  task automatic test_branch_prio();
    do_reset();
    idle_inputs();
    ex_br_taken = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8; ihit = 1'b0;
    #2;
    checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_prio_ctl got=%b exp=%b", ctl, C_BR); end
    tick();
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL br_prio_cnt got=%0d exp=0", stall_cnt); end
    idle_inputs();
    ihit = 1'b0;
    #2;
    checks++; if (ctl !== C_NOI) begin errors++; $display("FAIL noihit_ctl got=%b exp=%b", ctl, C_NOI); end
    tick();
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL noihit_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    idle_inputs();
    // halt behind an outstanding load waits for dhit
    mem_halt = 1'b1; mem_dREN = 1'b1; dhit = 1'b0;
    #2;
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL halt_wait_ctl got=%b exp=%b", ctl, C_ZERO); end
    tick();
    #2;
    checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL halt_wait2_ctl got=%b exp=%b", ctl, C_ZERO); end
    tick();
    dhit = 1'b1;
    #2;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL halt_hit_ctl got=%b exp=%b", ctl, C_RUN); end
    tick();
    idle_inputs();
    ihit = 1'b0;
    #2;
    checks++; if (ctl !== C_DRAIN) begin errors++; $display("FAIL drain_ctl got=%b exp=%b", ctl, C_DRAIN); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL drain_halt got=%b exp=0", halt); end
    tick();
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL drain_cnt got=%0d exp=2", stall_cnt); end
    for (int i = 0; i < 20; i++) begin
      ihit = i[0]; mem_halt = i[1]; ex_br_taken = i[2];
      #2;
      checks++; if (halt !== 1'b1 || ctl !== C_ZERO) begin errors++; $display("FAIL halted cyc=%0d halt=%b ctl=%b exp halt=1 ctl=%b", i, halt, ctl, C_ZERO); end
      tick();
    end
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL halted_cnt got=%0d exp=2", stall_cnt); end
    // async reset mid-HALTED
    idle_inputs();
    #2;
    nRST = 1'b0;
    #1;
    checks++; if (halt !== 1'b0 || stall_cnt !== 32'd0 || ctl !== C_ZERO) begin errors++; $display("FAIL halt_rst halt=%b cnt=%0d ctl=%b exp 0/0/%b", halt, stall_cnt, ctl, C_ZERO); end
    tick();
    nRST = 1'b1;
    #2;
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL halt_rst_run got=%b exp=%b", ctl, C_RUN); end
    tick();
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_rst_halt got=%b exp=0", halt); end
  endtask

  task automatic test_saturate();
    do_reset();
    idle_inputs();
    ihit = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (s_cnt !== 4'd15) begin errors++; $display("FAIL sat15 got=%0d exp=15", s_cnt); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (s_cnt !== 4'd15) begin errors++; $display("FAIL sat20 got=%0d exp=15", s_cnt); end
    checks++; if (stall_cnt !== 32'd20) begin errors++; $display("FAIL wide20 got=%0d exp=20", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_loaduse();
    test_dstall();
    test_branch_prio();
    test_halt();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
